// File: rtl/pipeline_control_if.sv
// Hazard inputs and latch controls exchanged between the pipeline datapath and its sequencer.
// master is the sequencer side; slave is the datapath side.
interface pipeline_control_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             exmem_dREN;
  logic             exmem_dWEN;
  logic             exmem_halt;
  logic             exmem_redirect;
  logic             idex_dREN;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             pc_en;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_flush;
  logic             exmem_stall;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, exmem_redirect,
           idex_dREN, idex_rt, ifid_rs, ifid_rt,
    output pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, exmem_flush, memwb_flush, halt, stall_cycles
  );

  modport slave (
    output ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, exmem_redirect,
           idex_dREN, idex_rt, ifid_rs, ifid_rt,
    input  pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, exmem_flush, memwb_flush, halt, stall_cycles
  );
endinterface

// File: rtl/pipeline_control.sv
// Pipeline sequencer: per-latch stall/flush and PC enable from cache hits, load-use hazards,
// MEM-stage redirects and halt; FSM for data-memory waits and halt draining plus a stall counter.
module pipeline_control #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  pipeline_control_if.master   bus
);
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MEMWAIT = 2'd1;
  localparam logic [1:0] HALTING = 2'd2;
  localparam logic [1:0] HALTED  = 2'd3;

  localparam int DRAIN_LOAD = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int DW         = $clog2(DRAIN_LOAD + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_LOAD);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(1);

  // Control vector: {pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, exmem_flush, memwb_flush}
  localparam logic [7:0] C_ADVANCE  = 8'b1000_0000;
  localparam logic [7:0] C_REDIRECT = 8'b1010_1010;
  localparam logic [7:0] C_LOADUSE  = 8'b0100_1000;
  localparam logic [7:0] C_IMISS    = 8'b0010_0000;
  localparam logic [7:0] C_DWAIT    = 8'b0101_0101;
  localparam logic [7:0] C_DRAIN    = 8'b0010_1010;
  localparam logic [7:0] C_HALTED   = 8'b0010_1011;

  logic [1:0]       state_reg, state_next;
  logic [DW-1:0]    drain_reg, drain_next;
  logic             halt_reg, halt_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic       mem_req;
  logic       lu_hazard;
  logic [7:0] flow_ctrl;
  logic [7:0] ctrl_sel;
  logic [7:0] ctrl_out;

  assign mem_req   = bus.exmem_dREN | bus.exmem_dWEN;
  assign lu_hazard = bus.idex_dREN & (bus.idex_rt != 5'd0) &
                     ((bus.idex_rt == bus.ifid_rs) | (bus.idex_rt == bus.ifid_rt));

  // Lower-priority RUN decisions, shared with the MEMWAIT release cycle.
  always_comb begin
    flow_ctrl = C_ADVANCE;
    if (bus.exmem_redirect)
      flow_ctrl = C_REDIRECT;
    else if (lu_hazard)
      flow_ctrl = C_LOADUSE;
    else if (!bus.ihit)
      flow_ctrl = C_IMISS;
  end

  always_comb begin
    ctrl_sel   = flow_ctrl;
    state_next = state_reg;
    drain_next = drain_reg;
    case (state_reg)
      RUN: begin
        if (bus.exmem_halt) begin
          ctrl_sel   = C_DRAIN;
          drain_next = DRAIN_INIT;
          state_next = HALTING;
        end else if (mem_req && !bus.dhit) begin
          ctrl_sel   = C_DWAIT;
          state_next = MEMWAIT;
        end
      end
      MEMWAIT: begin
        if (!bus.dhit)
          ctrl_sel = C_DWAIT;
        else
          state_next = RUN;
      end
      HALTING: begin
        ctrl_sel   = C_DRAIN;
        drain_next = drain_reg - 1'b1;
        if (drain_reg == DRAIN_LAST)
          state_next = HALTED;
      end
      default: ctrl_sel = C_HALTED;
    endcase
  end

  // A flush always wins over a hold on the same latch.
  always_comb begin
    ctrl_out    = ctrl_sel;
    ctrl_out[6] = ctrl_sel[6] & ~ctrl_sel[5];
    ctrl_out[4] = ctrl_sel[4] & ~ctrl_sel[3];
    ctrl_out[2] = ctrl_sel[2] & ~ctrl_sel[1];
  end

  always_comb begin
    halt_next      = halt_reg | (state_next == HALTED);
    stall_cnt_next = stall_cnt_reg;
    if (((state_reg == RUN) || (state_reg == MEMWAIT)) && !ctrl_out[7] && (stall_cnt_reg != '1))
      stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= RUN;
      drain_reg     <= '0;
      halt_reg      <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_reg     <= drain_next;
      halt_reg      <= halt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign bus.pc_en        = ctrl_out[7];
  assign bus.ifid_stall   = ctrl_out[6];
  assign bus.ifid_flush   = ctrl_out[5];
  assign bus.idex_stall   = ctrl_out[4];
  assign bus.idex_flush   = ctrl_out[3];
  assign bus.exmem_stall  = ctrl_out[2];
  assign bus.exmem_flush  = ctrl_out[1];
  assign bus.memwb_flush  = ctrl_out[0];
  assign bus.halt         = halt_reg;
  assign bus.stall_cycles = stall_cnt_reg;
endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Each cycle, produces per-latch stall and flush controls from:
  - cache hit signals
  - load-use hazards
  - control redirects resolved in MEM
  - halt
- Owns a small FSM for data-memory waits and halt draining, plus a saturating stall-cycle counter for performance debug.

Parameters:
DRAIN_CYCLES, 2, cycles after halt reaches MEM before halted asserts (lets WB retire)
CNT_W, 32, width of stall-cycle counter

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction cache hit this cycle
dhit  input  1  data cache hit this cycle
exmem_dREN  input  1  load in MEM stage
exmem_dWEN  input  1  store in MEM stage
exmem_halt  input  1  halt instruction in MEM stage
exmem_redirect  input  1  taken branch/jump/jr resolved in MEM
idex_dREN  input  1  load in EX stage
idex_rt  input  5  destination reg of load in EX
ifid_rs  input  5  rs of instruction in ID
ifid_rt  input  5  rt of instruction in ID
pc_en  output  1  PC register update enable
ifid_stall  output  1  hold IF/ID
ifid_flush  output  1  bubble IF/ID
idex_stall  output  1  hold ID/EX
idex_flush  output  1  bubble ID/EX
exmem_stall  output  1  hold EX/MEM
exmem_flush  output  1  bubble EX/MEM
memwb_flush  output  1  bubble MEM/WB
halt  output  1  sticky processor-halted flag
stall_cycles  output  CNT_W  saturating count of cycles with pc_en=0 in RUN or MEMWAIT

Behaviour:
- Reset (async, nRST=0):
  - state=RUN, drain counter=0, halt=0, stall_cycles=0.
  - All combinational outputs follow RUN decoding with zero inputs, i.e. pc_en=ihit.
- Definitions:
  - mem_req = exmem_dREN | exmem_dWEN.
  - lu_hazard = idex_dREN & (idex_rt!=0) & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- States: RUN, MEMWAIT, HALTING, HALTED. Outputs are Mealy, combinational from state and inputs. Flush has priority over stall at every latch.
- RUN, priority order (highest first):
  1. exmem_halt: pc_en=0; ifid_flush=idex_flush=exmem_flush=1. Load drain=DRAIN_CYCLES; next HALTING.
  2. mem_req & !dhit:
     - pc_en=0; ifid_stall=idex_stall=exmem_stall=1; memwb_flush=1.
     - If exmem_redirect is also asserted, the redirect is NOT taken this cycle. The EX/MEM latch is held, so the redirect is re-evaluated when dhit arrives.
     - Next MEMWAIT.
  3. exmem_redirect: pc_en=1 (target loaded); ifid_flush=idex_flush=exmem_flush=1. Stays RUN.
  4. lu_hazard: pc_en=0; ifid_stall=1; idex_flush=1 (one bubble). Downstream latches advance. Exactly one bubble per load: next cycle the load is in MEM and lu_hazard deasserts.
  5. !ihit: pc_en=0; ifid_flush=1 (bubble enters ID). Downstream advances normally.
  6. Otherwise: pc_en=1, all stall/flush=0.
- MEMWAIT:
  - While !dhit: same outputs as RUN rule 2.
  - On dhit: outputs as RUN evaluated with dhit=1 (rules 3-6 apply the same cycle, so the redirect/load-use takes effect); next RUN.
  - exmem_halt cannot coexist with mem_req.
- HALTING:
  - pc_en=0; ifid_flush=idex_flush=exmem_flush=1; memwb_flush=0.
  - Drain decrements each cycle; when drain==1, next HALTED.
  - DRAIN_CYCLES=0 is treated as 1.
- HALTED: pc_en=0; all flushes=1; halt=1 (registered, sticky until nRST). Inputs are ignored.
- stall_cycles: +1 on each cycle in RUN/MEMWAIT with pc_en=0. Saturates at all-ones; no wrap.
- Reset asserted mid-MEMWAIT or mid-HALTING: immediate return to RUN, counters cleared.

Test Plan:
- ihit=1 for 10 cycles, no hazards -> pc_en=1 every cycle, all stall/flush=0, stall_cycles=0.
- idex_dREN=1, idex_rt=8, ifid_rs=8 -> one cycle: pc_en=0, ifid_stall=1, idex_flush=1; same with idex_rt=0 -> no stall.
- exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> MEMWAIT for 3 cycles with stall on all upstream latches and memwb_flush=1; advance on the 4th; stall_cycles=3.
- exmem_redirect=1 with exmem_dWEN=1, dhit low 2 cycles -> no flush until dhit. Then on the dhit cycle: pc_en=1 and ifid/idex/exmem flush.
- exmem_halt=1 at cycle 5, DRAIN_CYCLES=2 -> flushes asserted cycles 5-7, halt=1 from cycle 8 and held. nRST pulse clears halt and returns to RUN.
- Force 2^CNT_W stall cycles with CNT_W=4 -> stall_cycles saturates at 15.
